// File: rtl/aes_pkg.sv
// Shared AES types and constants for the MixColumns datapath.
package aes_pkg;

    localparam int NUM_COLS = 4;
    localparam int BYTE_W   = 8;

    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

    typedef logic [BYTE_W-1:0] byte_t;
    // Ascending range so element 0 is the most significant byte (a0).
    typedef byte_t [0:NUM_COLS-1] column_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_t;

    localparam byte_t FWD_COEF [NUM_COLS] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam byte_t INV_COEF [NUM_COLS] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

endpackage

// File: rtl/gal8_mul.sv
// Combinational GF(2^8) multiplier, reduction polynomial x^8+x^4+x^3+x+1.
module gal8_mul
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic [BYTE_W-1:0] p
);

    byte_t acc;
    byte_t sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[BYTE_W-2:0], 1'b0} ^ (sh[BYTE_W-1] ? AES_POLY : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/mix_columns_seq_col.sv
// Single-column (Inv)MixColumns transform: a 4x4 grid of GF(2^8) products.
module mix_column_col
    import aes_pkg::*;
(
    input  logic    inv,
    input  column_t col_in,
    output column_t col_out
);

    byte_t prod [NUM_COLS][NUM_COLS];

    // Row r uses coefficient k = (c - r) mod 4 for input byte c (circulant matrix).
    for (genvar r = 0; r < NUM_COLS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            localparam int K = (c - r + NUM_COLS) % NUM_COLS;
            gal8_mul u_mul (
                .a (col_in[c]),
                .b (inv ? INV_COEF[K] : FWD_COEF[K]),
                .p (prod[r][c])
            );
        end
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < NUM_COLS; r++) begin
            col_out[r] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns, one column per cycle, valid/ready on both sides.
// Define INV_MIX_COLUMNS_EN to add the inv port selecting InvMixColumns.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
`ifdef INV_MIX_COLUMNS_EN
    ,
    input  logic         inv
`endif
);

    fsm_state_t   fsm_q, fsm_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] state_q, state_d;
    logic [127:0] state_out_q, state_out_d;
    logic         inv_q;

`ifdef INV_MIX_COLUMNS_EN
    logic         inv_d;
`else
    assign inv_q = 1'b0;
`endif

    // Column c occupies bits [127-32c -: 32], i.e. its LSB sits at 32*(3-c).
    logic [6:0] col_lsb;
    column_t    cur_col;
    column_t    mixed_col;

    assign col_lsb = {~col_cnt_q, 5'd0};
    assign cur_col = state_q[col_lsb +: 32];

    mix_column_col u_col (
        .inv     (inv_q),
        .col_in  (cur_col),
        .col_out (mixed_col)
    );

    always_comb begin
        fsm_d       = fsm_q;
        col_cnt_d   = col_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;
        state_out_d = state_out_q;
`ifdef INV_MIX_COLUMNS_EN
        inv_d       = inv_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = state_in;
                    col_cnt_d  = 2'd0;
                    in_ready_d = 1'b0;
                    fsm_d      = BUSY;
`ifdef INV_MIX_COLUMNS_EN
                    inv_d      = inv;
`endif
                end
            end
            BUSY: begin
                state_d[col_lsb +: 32] = mixed_col;
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_out_d = state_d;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d       = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            col_cnt_q   <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= '0;
            state_out_q <= '0;
`ifdef INV_MIX_COLUMNS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            col_cnt_q   <= col_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
            state_out_q <= state_out_d;
`ifdef INV_MIX_COLUMNS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq; exercises inverse mode when
// INV_MIX_COLUMNS_EN is defined.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef INV_MIX_COLUMNS_EN
    logic         inv;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] res;
    logic [127:0] res_b;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
`ifdef INV_MIX_COLUMNS_EN
        ,
        .inv       (inv)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; in_valid stays high with junk data while busy,
    // and inv is flipped after acceptance, neither of which may matter.
    task automatic apply_stimulus(input logic [127:0] din, input logic inv_sel,
                                  input int stall, output logic [127:0] dout);
        int lat;
        logic [127:0] held;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        check_output("in_ready_before_issue", {127'd0, in_ready}, 128'd1);
        state_in = din;
        in_valid = 1'b1;
`ifdef INV_MIX_COLUMNS_EN
        inv = inv_sel;
`else
        if (inv_sel) $display("[TB] note: inverse mode not built");
`endif
        tick();
        state_in = ~din;
`ifdef INV_MIX_COLUMNS_EN
        inv = ~inv_sel;
`endif
        check_output("in_ready_busy", {127'd0, in_ready}, 128'd0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_output("latency", 128'(lat), 128'd4);
        held = state_out;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_output("stall_state_out", state_out, held);
            check_output("stall_out_valid", {127'd0, out_valid}, 128'd1);
            check_output("stall_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("handshake_out_valid", {127'd0, out_valid}, 128'd0);
        check_output("handshake_in_ready", {127'd0, in_ready}, 128'd1);
        check_output("hold_after_drop", state_out, held);
        dout = held;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
        vecs[2] = '{128'h01000000_00010000_00000100_00000001, 128'h02010103_03020101_01030201_01010302};
        vecs[3] = '{128'h80000000_00800000_00000000_00000000, 128'h1b80809b_9b1b8080_00000000_00000000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
`ifdef INV_MIX_COLUMNS_EN
        inv       = 1'b0;
`endif
        tick();
        tick();
        check_output("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check_output("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check_output("reset_state_out", state_out, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("idle_in_ready", {127'd0, in_ready}, 128'd1);
            check_output("idle_out_valid", {127'd0, out_valid}, 128'd0);
            check_output("idle_state_out", state_out, 128'd0);
        end

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].din, 1'b0, (i == 1) ? 7 : 0, res);
            check_output($sformatf("fwd_vec%0d", i), res, vecs[i].dout);
        end

        // Reset lands on the second BUSY cycle.
        state_in = vecs[0].din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_out_valid", {127'd0, out_valid}, 128'd0);
        check_output("abort_in_ready", {127'd0, in_ready}, 128'd1);
        check_output("abort_state_out", state_out, 128'd0);
        tick();
        check_output("abort_stays_idle", {127'd0, out_valid}, 128'd0);
        apply_stimulus(vecs[2].din, 1'b0, 0, res);
        check_output("after_abort", res, vecs[2].dout);

        // Back-to-back with in_valid held high and out_ready high.
        out_ready = 1'b1;
        state_in  = vecs[0].din;
        in_valid  = 1'b1;
        tick();
        state_in  = vecs[3].din;
        tick();
        tick();
        tick();
        check_output("b2b_first_not_yet", {127'd0, out_valid}, 128'd0);
        tick();
        check_output("b2b_first_valid", {127'd0, out_valid}, 128'd1);
        res = state_out;
        check_output("b2b_first_result", res, vecs[0].dout);
        tick();
        check_output("b2b_handshake_valid", {127'd0, out_valid}, 128'd0);
        check_output("b2b_handshake_ready", {127'd0, in_ready}, 128'd1);
        tick();
        check_output("b2b_second_accept", {127'd0, in_ready}, 128'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_output("b2b_second_valid", {127'd0, out_valid}, 128'd1);
        res_b = state_out;
        check_output("b2b_second_result", res_b, vecs[3].dout);
        tick();
        out_ready = 1'b0;
        check_output("b2b_final_idle", {127'd0, in_ready}, 128'd1);

`ifdef INV_MIX_COLUMNS_EN
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i].dout, 1'b1, (i == 0) ? 3 : 0, res);
            check_output($sformatf("inv_vec%0d", i), res, vecs[i].din);
        end
        apply_stimulus(vecs[1].din, 1'b0, 0, res);
        check_output("fwd_after_inv", res, vecs[1].dout);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
